// File: rtl/mac3_seq_pkg.sv
// Shared types and constants for the mac3 sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac3_seq_pkg;

    // Depth of the mac3 pipeline; a result appears after this many advances.
    localparam int MAC3_PIPE_DEPTH = 4;
    // Bubbles needed to push the last real group out of the pipeline.
    localparam int MAC3_DRAIN_CNT  = MAC3_PIPE_DEPTH - 1;
    localparam int MAC3_DRAIN_W    = $clog2(MAC3_PIPE_DEPTH);
    // Width of the output-point index carried in a tag.
    localparam int MAC3_IDX_W      = 8;

    // Sequencer states, kept as plain constants for legacy tooling.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Shadow of one MAC pipeline slot.
    typedef struct packed {
        logic                  valid;  // slot carries a real group, not a bubble
        logic                  last;   // final group of its output point
        logic [MAC3_IDX_W-1:0] idx;    // output point the group belongs to
    } mac3_tag_t;

endpackage

// File: rtl/mac3_seq_tag_pipe.sv
// Tag shadow of the mac3 pipeline: shifts in lock-step with the MAC advance.
// Latency: a pushed tag reaches the tail after MAC3_PIPE_DEPTH advances.
// Backpressure: holds when adv=0; ack clears the tail valid unless a shift replaces it.
//
// Ports: clk, arst_n_in (async active-low), adv (MAC input_valid), push_tag
// (tag entering stage 1), ack (result written), tail_tag (stage 4 contents).
module mac3_seq_tag_pipe
    import mac3_seq_pkg::*;
(
    input  logic      clk,
    input  logic      arst_n_in,
    input  logic      adv,
    input  mac3_tag_t push_tag,
    input  logic      ack,
    output mac3_tag_t tail_tag
);

    mac3_tag_t stage_q [MAC3_PIPE_DEPTH];

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < MAC3_PIPE_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (adv) begin
            // A shift overwrites the tail, which also retires an acked result.
            stage_q[0] <= push_tag;
            for (int i = 1; i < MAC3_PIPE_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end else if (ack && stage_q[MAC3_PIPE_DEPTH-1].valid && stage_q[MAC3_PIPE_DEPTH-1].last) begin
            stage_q[MAC3_PIPE_DEPTH-1].valid <= 1'b0;
        end
    end

    assign tail_tag = stage_q[MAC3_PIPE_DEPTH-1];

endmodule

// File: rtl/mac3_seq_ctrl.sv
// Sequencer for one mac3 3-tap MAC: issues G groups per output for N outputs.
// Latency: result valid 4 cycles after its last group issues; done 1 cycle after drain.
// Backpressure: unacked result freezes the MAC (no issue, no bubble); op_valid=0 idles it.
//
// Ports: clk, arst_n_in (async active-low); start/cfg_groups/cfg_outputs job
// control; busy/done status; op_valid/op_ready + grp_idx/out_idx to operand
// fetch; mac_input_valid/mac_accumulate/mac_partial_sum to the MAC;
// res_valid/res_idx/res_ack to the result writer.
// Optional feature macro MAC3_SEQ_PSUM_EN adds psum_in/psum_valid/psum_ready,
// seeding each output point with an external partial sum.
module mac3_seq_ctrl
    import mac3_seq_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_groups,
    input  logic [CNT_W-1:0] cfg_outputs,
    output logic             busy,
    output logic             done,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [CNT_W-1:0] grp_idx,
    output logic [CNT_W-1:0] out_idx,
    output logic             mac_input_valid,
    output logic             mac_accumulate,
    output logic [ACC_W-1:0] mac_partial_sum,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_idx,
`ifdef MAC3_SEQ_PSUM_EN
    input  logic [ACC_W-1:0] psum_in,
    input  logic             psum_valid,
    output logic             psum_ready,
`endif
    input  logic             res_ack
);

    logic [1:0]              state_q;
    logic [CNT_W-1:0]        cfg_g_q;
    logic [CNT_W-1:0]        cfg_n_q;
    logic [CNT_W-1:0]        grp_q;
    logic [CNT_W-1:0]        out_q;
    logic [MAC3_DRAIN_W-1:0] drain_q;
    logic                    done_q;

    logic      stall, grp_first, grp_last, psum_ok;
    logic      issue, bubble, final_issue, drain_done;
    mac3_tag_t push_tag, tail_tag;

    assign stall     = res_valid & ~res_ack;
    assign grp_first = (grp_q == '0);
    assign grp_last  = (grp_q == cfg_g_q - CNT_W'(1));

`ifdef MAC3_SEQ_PSUM_EN
    // The first group of each output needs its seed partial sum present.
    assign psum_ok         = ~grp_first | psum_valid;
    assign psum_ready      = issue & grp_first;
    assign mac_partial_sum = psum_in;
`else
    assign psum_ok         = 1'b1;
    assign mac_partial_sum = '0;
`endif

    assign issue       = (state_q == ST_RUN) & op_valid & ~stall & psum_ok;
    assign bubble      = (state_q == ST_DRAIN) & ~stall
                         & (drain_q != MAC3_DRAIN_W'(MAC3_DRAIN_CNT));
    assign final_issue = issue & grp_last & (out_q == cfg_n_q - CNT_W'(1));
    // An ack in the same cycle frees the writer, so ~stall is enough here.
    assign drain_done  = (state_q == ST_DRAIN) & ~stall
                         & (drain_q == MAC3_DRAIN_W'(MAC3_DRAIN_CNT));

    assign mac_input_valid = issue | bubble;
    assign op_ready        = issue;
    // Bubbles accumulate so the in-flight sum is not disturbed by zero operands.
    assign mac_accumulate  = (issue & ~grp_first) | bubble;

    assign push_tag.valid = issue;
    assign push_tag.last  = grp_last;
    assign push_tag.idx   = MAC3_IDX_W'(out_q);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q <= ST_IDLE;
            cfg_g_q <= '0;
            cfg_n_q <= '0;
            grp_q   <= '0;
            out_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_groups == '0 || cfg_outputs == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cfg_g_q <= cfg_groups;
                            cfg_n_q <= cfg_outputs;
                            grp_q   <= '0;
                            out_q   <= '0;
                            drain_q <= '0;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        if (grp_last) begin
                            grp_q <= '0;
                            out_q <= out_q + CNT_W'(1);
                        end else begin
                            grp_q <= grp_q + CNT_W'(1);
                        end
                        if (final_issue) begin
                            drain_q <= '0;
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bubble) begin
                        drain_q <= drain_q + MAC3_DRAIN_W'(1);
                    end
                    if (drain_done) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mac3_seq_tag_pipe u_tag_pipe (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .adv       (mac_input_valid),
        .push_tag  (push_tag),
        .ack       (res_ack),
        .tail_tag  (tail_tag)
    );

    assign res_valid = tail_tag.valid & tail_tag.last;
    assign res_idx   = CNT_W'(tail_tag.idx);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign grp_idx   = grp_q;
    assign out_idx   = out_q;

endmodule

// File: doc/mac3_seq_ctrl.md
# mac3_seq_ctrl

Sequencer for one `mac3` three-tap pipelined MAC: walks a stream of output points, each accumulated over a configurable number of 3-tap groups. Drives the MAC's `input_valid`, `accumulate_internal` and `partial_sum_in`, and tracks in-flight groups with a 4-stage tag shadow pipeline. Presents each finished accumulator value to the memory writer with a valid/ack handshake, stalling the MAC until the value is written. Sits between the operand-fetch unit and the MAC / output writer inside a PE.

## Interface
- CNT_W, 8 — width of group/output counters and config fields
- ACC_W, 32 — MAC accumulator width (matches `mac3` ACCUMULATOR_WIDTH)
- clk  in  1  clock
- arst_n_in  in  1  reset; asynchronous, active-low; one clock
- start  in  1  one-cycle pulse; latches cfg and begins a job when idle
- cfg_groups  in  CNT_W  3-tap groups per output point (G)
- cfg_outputs  in  CNT_W  output points per job (N)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job end
- op_valid  in  1  operand fetch has a0..b2 for (out_idx, grp_idx) on the MAC inputs
- op_ready  out  1  group consumed this cycle
- grp_idx  out  CNT_W  group currently requested
- out_idx  out  CNT_W  output point currently requested
- mac_input_valid  out  1  to MAC `input_valid` (pipeline advance)
- mac_accumulate  out  1  to MAC `accumulate_internal`
- mac_partial_sum  out  ACC_W  to MAC `partial_sum_in`
- res_valid  out  1  MAC `out` holds a finished result
- res_idx  out  CNT_W  output point of presented result
- res_ack  in  1  result written (MAC `out_written_to_mem`)

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start with G≠0 and N≠0 → latch cfg, clear counters, RUN. start with G=0 or N=0 → done pulse next cycle, stay IDLE. start while busy ignored.
- stall = res_valid & ~res_ack.
- RUN: issue = op_valid & ~stall. On issue: mac_input_valid=1, op_ready=1, mac_accumulate = (grp_idx≠0), tag {valid=1, last=(grp_idx==G-1), idx=out_idx} pushed. grp_idx wraps at G-1 and increments out_idx. Issue of group (N-1, G-1) → DRAIN with drain count 0. No issue → mac_input_valid=0, MAC frozen.
- DRAIN: each ~stall cycle issues a bubble (mac_input_valid=1, tag valid=0, mac_accumulate=1), drain count +1; after 3 bubbles hold mac_input_valid=0. Go IDLE with done pulse once 3 bubbles issued and no res_valid pending (ack counts).
- Tag pipeline: 4 stages, shifts only when mac_input_valid=1. res_valid = stage4.valid & stage4.last. res_ack while res_valid clears stage4.valid (a simultaneous shift loads stage3 instead).
- Non-last groups reaching stage4 never raise res_valid.
- busy = state≠IDLE.

## Timing
- Reset: state IDLE; busy, done, op_ready, mac_input_valid, mac_accumulate, res_valid = 0; mac_partial_sum, grp_idx, out_idx, res_idx = 0; all tags invalid.
- op_ready, mac_input_valid, mac_accumulate combinational from state, op_valid, res_ack.
- Latency: last group issued in cycle t with 3 further advances at t+1..t+3 → res_valid in cycle t+4.
- Throughput: one group per cycle with op_valid=1 and res_ack same-cycle as res_valid; one output per G cycles.
- res_ack held low: MAC frozen, result stable; res_ack without res_valid ignored.
- Reset mid-job: immediate return to IDLE, in-flight tags discarded, no done.

## Configuration
- MAC3_SEQ_PSUM_EN defined: adds psum_in (in, ACC_W), psum_valid (in, 1), psum_ready (out, 1). Issue of grp_idx=0 additionally requires psum_valid; psum_ready=issue & grp_idx==0; mac_partial_sum=psum_in.
- Undefined: ports absent, mac_partial_sum tied 0; each output restarts from zero.

## Structure
- Package mac3_seq_pkg: state enum, tag struct {valid, last, idx}, constant MAC3_PIPE_DEPTH=4, drain count = MAC3_PIPE_DEPTH-1.
- Sub-module mac3_seq_tag_pipe: enabled tag shift register with stage4 clear-on-ack.

## Test plan
- G=3, N=2, op_valid=1, res_ack=1: mac_accumulate 0,1,1,0,1,1; res_valid in cycles 7 and 10 (start=cycle 0) with res_idx 0,1; done one cycle after second result.
- Same, res_ack held low 5 cycles at first result: mac_input_valid=0 throughout, MAC out stable, no op_ready; resumes on ack.
- G=1, N=4, op_valid toggling 1/0: mac_accumulate always 0, four results in order 0..3, tags advance only on valid cycles.
- start with G=0: done pulse next cycle, mac_input_valid never asserted; start during busy ignored.
- arst_n_in low mid-RUN: all outputs 0 immediately, no done; new start works normally.
- MAC3_SEQ_PSUM_EN, psum_valid late by 2 cycles on each grp_idx=0: issue withheld, mac_partial_sum=psum_in on first group, result = psum_in + sum of products.
